bcd_to_gray_converter: RTL and testbench
========================================

# bcd_to_gray_converter

Registered converter that maps one or more packed BCD digits to their 4-bit reflected Gray codes, one Gray nibble per digit. It sits in the converters group between BCD-producing logic (counters, decoders) and consumers that need single-bit-change encodings. It also flags non-BCD input nibbles (values 10–15) per digit.

## Interface
- DIGITS, default 1: number of packed BCD digits processed in parallel (≥1).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies bcd for capture this cycle.
- bcd  input  4*DIGITS  packed BCD digits; digit i at bits [4i+3:4i], digit 0 least significant.
- out_valid  output  1  gray/digit_err/any_err hold a fresh conversion.
- gray  output  4*DIGITS  packed Gray codes, same digit ordering as bcd.
- digit_err  output  DIGITS  bit i set when input digit i was greater than 9.
- any_err  output  1  OR-reduction of digit_err.

## Operation
- Per digit, with input nibble b[3:0]: g = b ^ (b >> 1), i.e. g3=b3, g2=b3^b2, g1=b2^b1, g0=b1^b0.
- Required mapping: 0→0000, 1→0001, 2→0011, 3→0010, 4→0110, 5→0111, 6→0101, 7→0100, 8→1100, 9→1101.
- Invalid digit (b > 9): that digit's gray nibble is forced to 0000 and its digit_err bit is set; other digits convert normally and are unaffected.
- any_err = |digit_err, registered together with the rest of the outputs.
- Digits are independent; there is no carry or interaction between digits.
- in_valid=0: gray, digit_err and any_err hold their previous values; out_valid drops to 0.
- No backpressure: every valid input is converted and presented; the downstream must sample on out_valid.

## Timing
- Latency: exactly 1 clock. bcd sampled on the rising edge where in_valid=1 appears on gray the same edge, with out_valid=1 for that single cycle.
- Back-to-back in_valid for N cycles gives N consecutive out_valid cycles; throughput is one conversion per clock.
- Reset (asynchronous assertion, immediate): gray=0, digit_err=0, any_err=0, out_valid=0. Outputs hold these values while rst=1, regardless of in_valid.
- Reset deassertion: the first capture happens at the first rising edge with rst=0 and in_valid=1.
- Reset asserted in the same cycle as in_valid: the input is dropped and no out_valid follows.
- All outputs come straight from flops, with no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst mid-stream with in_valid=1 → all outputs 0 immediately (before the next edge); no out_valid after release until new in_valid.
- Full digit sweep (DIGITS=1): drive bcd 0..9 back-to-back with in_valid=1 → one cycle later gray = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101 in order, out_valid continuously 1, any_err=0.
- Invalid codes: bcd=1010, then 1111 → gray=0000, digit_err=1, any_err=1; next input 1001 → gray=1101, digit_err=0.
- Hold behaviour: bcd=0100 with in_valid=1, then bcd=1001 with in_valid=0 for 3 cycles → gray stays 0110 and out_valid=1 for exactly one cycle.
- Multi-digit (DIGITS=2): bcd=8'h93 → gray=8'hD2, digit_err=00; bcd=8'hB2 → gray=8'h03, digit_err=10, any_err=1.
- Exhaustive check: all 16 nibble values per digit, compared against the XOR formula for 0–9 and against 0000 plus the error flag for 10–15.

Source files
------------

// File: rtl/bcd_to_gray_converter_if.sv
// Handshake bundle for the BCD-to-Gray converter: an input side qualified by
// in_valid and a registered output side qualified by out_valid.
interface bcd_to_gray_converter_if #(
    parameter int DIGITS = 1
);
    logic                  in_valid;
    logic [4*DIGITS-1:0]   bcd;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   gray;
    logic [DIGITS-1:0]     digit_err;
    logic                  any_err;

    // Producer of BCD digits and consumer of the Gray result.
    modport master (
        output in_valid,
        output bcd,
        input  out_valid,
        input  gray,
        input  digit_err,
        input  any_err
    );

    // The converter itself.
    modport slave (
        input  in_valid,
        input  bcd,
        output out_valid,
        output gray,
        output digit_err,
        output any_err
    );
endinterface

// File: rtl/bcd_to_gray_converter.sv
// Registered BCD-to-Gray converter. Every packed BCD digit is mapped to its
// 4-bit reflected Gray code in parallel; nibbles above 9 produce 0000 and
// raise that digit's error flag. All outputs are flops, one cycle of latency.
module bcd_to_gray_converter #(
    parameter int DIGITS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    bcd_to_gray_converter_if.slave       bus
);

    // Gray code of one BCD digit; a non-BCD nibble maps to 0000 so a bad
    // digit never looks like a plausible code downstream.
    function automatic logic [3:0] digit_to_gray(input logic [3:0] b);
        logic [3:0] g;
        if (b > 4'd9) begin
            g = 4'b0000;
        end else begin
            g = b ^ (b >> 1);
        end
        return g;
    endfunction

    logic [4*DIGITS-1:0] gray_d,      gray_q;
    logic [DIGITS-1:0]   digit_err_d, digit_err_q;
    logic                any_err_d,   any_err_q;
    logic                out_valid_d, out_valid_q;

    // Next-state: convert every digit when in_valid, otherwise keep the last result.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        gray_d      = gray_q;
        digit_err_d = digit_err_q;
        any_err_d   = any_err_q;
        out_valid_d = bus.in_valid;

        if (bus.in_valid) begin
            for (int i = 0; i < DIGITS; i++) begin
                gray_d[4*i +: 4] = digit_to_gray(bus.bcd[4*i +: 4]);
                digit_err_d[i]   = (bus.bcd[4*i +: 4] > 4'd9);
            end
            // Reduce the freshly computed flags so any_err lines up with digit_err.
            any_err_d = |digit_err_d;
        end
    end

    // Output registers with asynchronous reset; an input seen during reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q      <= '0;
            digit_err_q <= '0;
            any_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            gray_q      <= gray_d;
            digit_err_q <= digit_err_d;
            any_err_q   <= any_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.gray      = gray_q;
    assign bus.digit_err = digit_err_q;
    assign bus.any_err   = any_err_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_to_gray_converter.sv
// Self-checking bench: a 1-digit and a 2-digit converter driven in lockstep,
// compared against a table-based reference model after every clock.
module tb_bcd_to_gray_converter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_to_gray_converter_if #(.DIGITS(1)) if1 ();
    bcd_to_gray_converter_if #(.DIGITS(2)) if2 ();

    bcd_to_gray_converter #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bcd_to_gray_converter #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reflected Gray codes of the decimal digits, written out as listed values.
    int gray_tab [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};

    // Expected outputs of each instance.
    int e1_gray, e1_err, e1_any, e1_vld;
    int e2_gray, e2_err, e2_any, e2_vld;

    function automatic void ref_conv(input int digits, input int value,
                                     output int g, output int e);
        int nib;
        g = 0;
        e = 0;
        for (int d = 0; d < digits; d++) begin
            nib = (value / (16 ** d)) % 16;
            if (nib <= 9) g = g + gray_tab[nib] * (16 ** d);
            else          e = e + (2 ** d);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".d1.out_valid"}, 32'(if1.out_valid), e1_vld);
        check({tag, ".d1.gray"},      32'(if1.gray),      e1_gray);
        check({tag, ".d1.digit_err"}, 32'(if1.digit_err), e1_err);
        check({tag, ".d1.any_err"},   32'(if1.any_err),   e1_any);
        check({tag, ".d2.out_valid"}, 32'(if2.out_valid), e2_vld);
        check({tag, ".d2.gray"},      32'(if2.gray),      e2_gray);
        check({tag, ".d2.digit_err"}, 32'(if2.digit_err), e2_err);
        check({tag, ".d2.any_err"},   32'(if2.any_err),   e2_any);
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, update the
    // model for that edge, and return at the following negedge.
    task automatic apply(input logic v, input int b1, input int b2);
        int g, e;
        if1.in_valid = v;
        if1.bcd      = 4'(b1);
        if2.in_valid = v;
        if2.bcd      = 8'(b2);
        @(posedge clk);
        e1_vld = int'(v);
        e2_vld = int'(v);
        if (v) begin
            ref_conv(1, b1 % 16, g, e);
            e1_gray = g; e1_err = e; e1_any = (e != 0) ? 1 : 0;
            ref_conv(2, b2 % 256, g, e);
            e2_gray = g; e2_err = e; e2_any = (e != 0) ? 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        e1_gray = 0; e1_err = 0; e1_any = 0; e1_vld = 0;
        e2_gray = 0; e2_err = 0; e2_any = 0; e2_vld = 0;
    endtask

    initial begin
        // Reset with in_valid asserted: nothing must be captured.
        rst          = 1'b1;
        if1.in_valid = 1'b1;
        if1.bcd      = 4'd5;
        if2.in_valid = 1'b1;
        if2.bcd      = 8'h55;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        if1.in_valid = 1'b0;
        if2.in_valid = 1'b0;
        rst = 1'b0;
        apply(1'b0, 0, 0);
        check_all("post_reset_idle");

        // Sweep 0..9 back to back; spec mapping also checked by literal.
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, i, i * 16 + (9 - i));
            check_all($sformatf("sweep%0d", i));
        end

        // Invalid codes followed by a recovery digit.
        apply(1'b1, 10, 8'hA0);
        check_all("inv10");
        check("inv10.literal", 32'(if1.gray), 32'h0);
        apply(1'b1, 15, 8'h0F);
        check_all("inv15");
        apply(1'b1, 9, 8'h99);
        check_all("recover9");
        check("recover9.literal", 32'(if1.gray), 32'hD);

        // Hold behaviour: one valid, then three idle cycles with changed input.
        apply(1'b1, 4, 8'h44);
        check_all("hold_load");
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 9, 8'h99);
            check_all($sformatf("hold%0d", i));
            check($sformatf("hold%0d.literal", i), 32'(if1.gray), 32'h6);
        end

        // Multi-digit directed vectors.
        apply(1'b1, 3, 8'h93);
        check_all("md93");
        check("md93.literal_gray", 32'(if2.gray), 32'hD2);
        check("md93.literal_err",  32'(if2.digit_err), 32'h0);
        apply(1'b1, 2, 8'hB2);
        check_all("mdB2");
        check("mdB2.literal_gray", 32'(if2.gray), 32'h03);
        check("mdB2.literal_err",  32'(if2.digit_err), 32'h2);
        check("mdB2.literal_any",  32'(if2.any_err), 32'h1);

        // Exhaustive: every nibble on the 1-digit unit, every byte on the 2-digit one.
        for (int i = 0; i < 256; i++) begin
            apply(1'b1, i % 16, i);
            check_all($sformatf("exh%0d", i));
        end

        // Random traffic with random gaps in in_valid.
        for (int i = 0; i < 300; i++) begin
            apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)));
            check_all($sformatf("rnd%0d", i));
        end

        // Mid-stream asynchronous reset: outputs clear before the next edge.
        apply(1'b1, 7, 8'h87);
        check_all("pre_rst");
        if1.in_valid = 1'b1;
        if1.bcd      = 4'd8;
        if2.in_valid = 1'b1;
        if2.bcd      = 8'h18;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b0;
        apply(1'b0, 8, 8'h18);
        check_all("rst_release_idle");
        apply(1'b1, 6, 8'h61);
        check_all("rst_first_capture");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
